// File: rtl/digit_scan_ctrl_pkg.sv
// rtl/digit_scan_ctrl_pkg.sv - shared types and constants for the six-digit scan controller
package digit_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCAN
  } state_t;

  localparam logic [2:0] POS_SEC_ONES  = 3'd0;
  localparam logic [2:0] POS_SEC_TENS  = 3'd1;
  localparam logic [2:0] POS_MIN_ONES  = 3'd2;
  localparam logic [2:0] POS_MIN_TENS  = 3'd3;
  localparam logic [2:0] POS_HOUR_ONES = 3'd4;
  localparam logic [2:0] POS_HOUR_TENS = 3'd5;

  localparam logic [3:0] DASH        = 4'hF;
  localparam logic [3:0] BLANK_DIGIT = 4'h0;
  localparam logic [5:0] AN_OFF      = 6'b111111;

  localparam logic [5:0] SEC_MIN_LIMIT = 6'd60;
  localparam logic [5:0] HOUR_LIMIT    = 6'd24;

  localparam int PRESC_W = 20;

endpackage

// File: rtl/digit_scan_ctrl_tens_ones_split.sv
// rtl/digit_scan_ctrl_tens_ones_split.sv - combinational tens/ones splitter with range check
module tens_ones_split (
  input  logic [5:0] i_value,
  input  logic [5:0] i_limit,
  output logic [2:0] o_tens,
  output logic [3:0] o_ones,
  output logic       o_invalid
);

  logic [5:0] w_diff;

  // Threshold compare instead of a divider; inputs never exceed 63.
  always_comb begin
    o_tens = 3'd0;
    if (i_value >= 6'd50)      o_tens = 3'd5;
    else if (i_value >= 6'd40) o_tens = 3'd4;
    else if (i_value >= 6'd30) o_tens = 3'd3;
    else if (i_value >= 6'd20) o_tens = 3'd2;
    else if (i_value >= 6'd10) o_tens = 3'd1;
    w_diff    = i_value - (6'(o_tens) * 6'd10);
    o_ones    = w_diff[3:0];
    o_invalid = (i_value >= i_limit);
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// rtl/digit_scan_ctrl.sv - six-digit display scan controller; option macro DIGIT_SCAN_LEAD_BLANK_EN
module digit_scan_ctrl
  import digit_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  output logic [5:0] an,
  output logic [3:0] digit,
  output logic       frame_done
);

  localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(SCAN_DIV - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [2:0]         r_p;
  logic [2:0]         w_p_next;
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] w_presc_next;
  logic [5:0]         r_snap_sec;
  logic [5:0]         r_snap_min;
  logic [4:0]         r_snap_hour;
  logic               w_tc;
  logic               w_frame_end;
  logic               w_lead_blank;
  logic [5:0]         w_split_value;
  logic [5:0]         w_split_limit;
  logic [2:0]         w_tens;
  logic [3:0]         w_ones;
  logic               w_invalid;
  logic [3:0]         w_field_digit;

  assign w_tc = (r_presc == PRESC_TC);

  always_comb begin
    w_state_next = r_state;
    w_p_next     = r_p;
    w_presc_next = r_presc;
    w_frame_end  = 1'b0;
    if (!en) begin
      w_state_next = ST_IDLE;
      w_p_next     = POS_SEC_ONES;
      w_presc_next = '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_LOAD: begin
          w_state_next = (r_state == ST_IDLE) ? ST_LOAD : ST_SCAN;
          w_p_next     = POS_SEC_ONES;
          w_presc_next = '0;
        end
        ST_SCAN: begin
          if (w_tc) begin
            w_presc_next = '0;
            if (r_p == POS_HOUR_TENS) begin
              w_state_next = ST_LOAD;
              w_p_next     = POS_SEC_ONES;
              w_frame_end  = 1'b1;
            end else begin
              w_p_next = r_p + 3'd1;
            end
          end else begin
            w_presc_next = r_presc + 1'b1;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // The splitter looks at the upcoming position so an and digit register together.
  always_comb begin
    case (w_p_next[2:1])
      2'd0:    begin w_split_value = r_snap_sec;         w_split_limit = SEC_MIN_LIMIT; end
      2'd1:    begin w_split_value = r_snap_min;         w_split_limit = SEC_MIN_LIMIT; end
      default: begin w_split_value = {1'b0, r_snap_hour}; w_split_limit = HOUR_LIMIT;    end
    endcase
    w_field_digit = w_invalid ? DASH : (w_p_next[0] ? {1'b0, w_tens} : w_ones);
  end

  tens_ones_split u_split (
    .i_value   (w_split_value),
    .i_limit   (w_split_limit),
    .o_tens    (w_tens),
    .o_ones    (w_ones),
    .o_invalid (w_invalid)
  );

`ifdef DIGIT_SCAN_LEAD_BLANK_EN
  assign w_lead_blank = (w_p_next == POS_HOUR_TENS) && (r_snap_hour < 5'd10);
`else
  assign w_lead_blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_p         <= POS_SEC_ONES;
      r_presc     <= '0;
      r_snap_sec  <= '0;
      r_snap_min  <= '0;
      r_snap_hour <= '0;
      an          <= AN_OFF;
      digit       <= BLANK_DIGIT;
      frame_done  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_p        <= w_p_next;
      r_presc    <= w_presc_next;
      frame_done <= w_frame_end;
      if (w_state_next == ST_LOAD && r_state != ST_LOAD) begin
        r_snap_sec  <= sec;
        r_snap_min  <= min;
        r_snap_hour <= hour;
      end
      if (w_state_next == ST_SCAN && !w_lead_blank) begin
        an    <= ~(6'd1 << w_p_next);
        digit <= w_field_digit;
      end else begin
        an    <= AN_OFF;
        digit <= BLANK_DIGIT;
      end
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb/tb_digit_scan_ctrl.sv - table-driven self-checking bench for digit_scan_ctrl
module tb_digit_scan_ctrl;

  localparam int DIV = 4;
`ifdef DIGIT_SCAN_LEAD_BLANK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  typedef struct {
    logic [5:0]  s;
    logic [5:0]  m;
    logic [4:0]  h;
    logic [23:0] e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [5:0] an;
  logic [3:0] digit;
  logic       frame_done;

  int total = 0;
  int bad   = 0;
  vec_t tbl[7];

  always #5 clk = ~clk;

  digit_scan_ctrl #(.SCAN_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sec        (sec),
    .min        (min),
    .hour       (hour),
    .an         (an),
    .digit      (digit),
    .frame_done (frame_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_blank(input string name, input logic fd);
    @(negedge clk);
    chk({name, " an"}, 32'(an), 32'h3F);
    chk({name, " digit"}, 32'(digit), 32'h0);
    chk({name, " frame_done"}, 32'(frame_done), 32'(fd));
  endtask

  // Checks scan cycles first..first+n-1 of a frame (cycle c shows position c/DIV).
  task automatic check_cycles(input logic [23:0] d, input logic [4:0] hsnap, input int first, input int n);
    for (int c = first; c < first + n; c++) begin
      int p;
      logic blank;
      logic [5:0] exp_an;
      logic [3:0] exp_dg;
      @(negedge clk);
      p      = c / DIV;
      blank  = LB && (p == 5) && (hsnap < 5'd10);
      exp_an = blank ? 6'h3F : ~(6'd1 << p);
      exp_dg = blank ? 4'h0 : d[p*4 +: 4];
      chk($sformatf("an p%0d c%0d", p, c), 32'(an), 32'(exp_an));
      chk($sformatf("digit p%0d c%0d", p, c), 32'(digit), 32'(exp_dg));
      chk($sformatf("no frame_done c%0d", c), 32'(frame_done), 32'h0);
    end
  endtask

  task automatic start(input logic [5:0] s, input logic [5:0] m, input logic [4:0] h);
    @(negedge clk);
    en = 1'b0; sec = s; min = m; hour = h;
    check_blank("idle", 1'b0);
    en = 1'b1;
    check_blank("load", 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sec = '0; min = '0; hour = '0;
    tbl[0] = '{6'd37, 6'd5,  5'd23, 24'h230537};
    tbl[1] = '{6'd0,  6'd0,  5'd0,  24'h000000};
    tbl[2] = '{6'd59, 6'd59, 5'd23, 24'h235959};
    tbl[3] = '{6'd37, 6'd60, 5'd24, 24'hFFFF37};
    tbl[4] = '{6'd60, 6'd10, 5'd17, 24'h1710FF};
    tbl[5] = '{6'd9,  6'd40, 5'd7,  24'h074009};
    tbl[6] = '{6'd63, 6'd63, 5'd31, 24'hFFFFFF};

    repeat (2) @(posedge clk);
    check_blank("reset", 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      start(tbl[i].s, tbl[i].m, tbl[i].h);
      check_cycles(tbl[i].e, tbl[i].h, 0, 6 * DIV);
      check_blank($sformatf("frame end v%0d", i), 1'b1);
    end

    // Input change mid-frame only shows up in the following frame.
    start(6'd37, 6'd5, 5'd23);
    check_cycles(24'h230537, 5'd23, 0, 3 * DIV + 1);
    sec = 6'd38;
    check_cycles(24'h230537, 5'd23, 3 * DIV + 1, 3 * DIV - 1);
    check_blank("frame end old", 1'b1);
    check_cycles(24'h230538, 5'd23, 0, 6 * DIV);
    check_blank("frame end new", 1'b1);

    // en dropped at p=2, then re-enabled: LOAD then restart at p=0.
    start(6'd37, 6'd5, 5'd23);
    check_cycles(24'h230537, 5'd23, 0, 2 * DIV + 1);
    en = 1'b0;
    check_blank("en drop", 1'b0);
    en = 1'b1;
    check_blank("reload", 1'b0);
    check_cycles(24'h230537, 5'd23, 0, 6 * DIV);
    check_blank("frame end after reload", 1'b1);

    // en dropped exactly at the final terminal count suppresses frame_done.
    start(6'd12, 6'd34, 5'd9);
    check_cycles(24'h093412, 5'd9, 0, 6 * DIV);
    en = 1'b0;
    check_blank("en drop at tc", 1'b0);

    // Reset mid-frame blanks at once; snapshot is re-taken on the next LOAD.
    start(6'd37, 6'd5, 5'd23);
    check_cycles(24'h230537, 5'd23, 0, DIV + 2);
    rst = 1'b1;
    check_blank("mid reset", 1'b0);
    rst = 1'b0;
    check_blank("load after reset", 1'b0);
    check_cycles(24'h230537, 5'd23, 0, 6 * DIV);
    check_blank("frame end after reset", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
